nclic_csr_unit: RTL and testbench

CSR-side responder for the nested interrupt controller. It accepts CSR requests (op, address, operand) from the core's CSR stage over a valid/ready handshake and performs the atomic read-modify-write on the per-interrupt configuration registers (prio, enabled, pending). It returns the old value on a valid/ready response channel. It also owns the pending bits: it sets them on hardware source rising edges and clears them on dispatcher acknowledge. Its configuration array output feeds the arbiter/dispatcher.

---
 rtl/types_pkg.sv | 53 +++++
 rtl/nclic_cfg_reg.sv | 38 +++
 rtl/nclic_csr_unit.sv | 112 +++++++++++
 tb/tb_nclic_csr_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the nested interrupt controller: CSR word layout, per-interrupt
// configuration record, CSR opcodes and the CSR responder state encoding.
package types_pkg;

  localparam int IntAmount  = 8;
  localparam int Priorities = 8;
  localparam int PrioWidth  = $clog2(Priorities);
  localparam int SlotWidth  = $clog2(IntAmount);

  typedef logic [31:0]          word;
  typedef logic [11:0]          CsrAddrT;
  typedef logic [SlotWidth-1:0] slot_t;
  // One extra bit so the dispatcher can present indices beyond the last line.
  typedef logic [SlotWidth:0]   IntIdx;

  localparam CsrAddrT CsrBase = 12'hB00;

  typedef enum logic [2:0] {
    ECALL  = 3'b000,
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_t;

  typedef struct packed {
    logic [PrioWidth-1:0] prio;
    logic                 enabled;
    logic                 pending;
  } int_config_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} nclic_csr_state_t;

  function automatic int_config_t csr_to_cfg(input word w);
    int_config_t c;
    c.pending = w[0];
    c.enabled = w[1];
    c.prio    = w[PrioWidth+1:2];
    return c;
  endfunction

  function automatic word cfg_to_csr(input int_config_t c);
    word w;
    w                 = '0;
    w[0]              = c.pending;
    w[1]              = c.enabled;
    w[PrioWidth+1:2]  = c.prio;
    return w;
  endfunction

endpackage

// File: rtl/nclic_cfg_reg.sv
// Configuration register for one interrupt line: prio/enabled written by CSR,
// pending set by source rising edge, cleared by acknowledge, else CSR-written.
module nclic_cfg_reg
  import types_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        src,
  input  logic        we,
  input  int_config_t wdata,
  input  logic        ack_clr,
  output int_config_t cfg
);

  logic src_q;
  logic rise;

  assign rise = src & ~src_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= 1'b0;
      cfg   <= '0;
    end else begin
      src_q <= src;
      if (we) begin
        cfg.prio    <= wdata.prio;
        cfg.enabled <= wdata.enabled;
      end
      if (rise)         cfg.pending <= 1'b1;
      else if (ack_clr) cfg.pending <= 1'b0;
      else if (we)      cfg.pending <= wdata.pending;
    end
  end

endmodule

// File: rtl/nclic_csr_unit.sv
// CSR responder for the nested interrupt controller: three-state request/execute/
// respond sequencer performing atomic read-modify-write on per-interrupt config.
module nclic_csr_unit
  import types_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  csr_op_t                       req_op,
  input  CsrAddrT                       req_addr,
  input  word                           req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output word                           rsp_rdata,
  output logic                          rsp_err,
  input  logic [IntAmount-1:0]          int_src,
  input  logic                          ack_valid,
  input  IntIdx                         ack_idx,
  output int_config_t [IntAmount-1:0]   cfg
);

  nclic_csr_state_t state, state_nxt;
  csr_op_t          op_q;
  CsrAddrT          addr_q;
  word              wdata_q;

  CsrAddrT          offset;
  slot_t            slot;
  logic             hit;
  logic             illegal;
  logic             writes;
  logic             err;
  logic             do_write;
  word              old_word;
  word              new_word;

  logic [IntAmount-1:0] we;
  logic [IntAmount-1:0] ack_clr;

  assign req_ready = reset_n && (state == IDLE);
  assign rsp_valid = (state == RESP);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    offset   = addr_q - CsrBase;
    hit      = (addr_q >= CsrBase) && (offset < CsrAddrT'(IntAmount));
    slot     = offset[SlotWidth-1:0];
    old_word = hit ? cfg_to_csr(cfg[slot]) : '0;
    new_word = old_word;
    illegal  = 1'b0;
    writes   = 1'b0;
    case (op_q)
      CSRRW, CSRRWI: begin new_word = wdata_q;             writes = 1'b1;     end
      CSRRS, CSRRSI: begin new_word = old_word | wdata_q;  writes = |wdata_q; end
      CSRRC, CSRRCI: begin new_word = old_word & ~wdata_q; writes = |wdata_q; end
      default:       illegal = 1'b1;
    endcase
    err      = illegal || !hit;
    do_write = (state == EXEC) && !err && writes;
  end

  for (genvar i = 0; i < IntAmount; i++) begin : g_int
    assign we[i]      = do_write && (slot == slot_t'(i));
    assign ack_clr[i] = ack_valid && (ack_idx == IntIdx'(i));

    nclic_cfg_reg u_cfg_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .src     (int_src[i]),
      .we      (we[i]),
      .wdata   (csr_to_cfg(new_word)),
      .ack_clr (ack_clr[i]),
      .cfg     (cfg[i])
    );
  end

  // NOTE: request latches are reset too, so a reset mid-transaction leaves no
  // stale opcode/address to decode; they carry no storage array that would make this costly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= ECALL;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == EXEC) begin
        rsp_rdata <= err ? '0 : old_word;
        rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_nclic_csr_unit.sv
// Directed bench for nclic_csr_unit: expected responses are queued at request
// acceptance and compared when the response handshake occurs.
module tb_nclic_csr_unit;
  import types_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        req_valid;
  logic                        req_ready;
  csr_op_t                     req_op;
  CsrAddrT                     req_addr;
  word                         req_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  word                         rsp_rdata;
  logic                        rsp_err;
  logic [IntAmount-1:0]        int_src;
  logic                        ack_valid;
  IntIdx                       ack_idx;
  int_config_t [IntAmount-1:0] cfg;

  typedef struct packed {
    logic err;
    word  rdata;
  } rsp_t;

  rsp_t sb[$];
  word  model[IntAmount];
  int   tests = 0;
  int   fails = 0;

  nclic_csr_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .int_src   (int_src),
    .ack_valid (ack_valid),
    .ack_idx   (ack_idx),
    .cfg       (cfg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input word obs, input word exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input string tag);
    for (int i = 0; i < IntAmount; i++)
      check($sformatf("%s_cfg%0d", tag, i), cfg_to_csr(cfg[i]), model[i]);
  endtask

  // Present a request, wait (bounded) for acceptance, queue its expected
  // response and verify the two-cycle latency. src_exec is driven in EXEC.
  task automatic issue(input csr_op_t op, input CsrAddrT a, input word d,
                       input logic e, input word r,
                       input logic [IntAmount-1:0] src_exec);
    int waited = 0;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_at_issue", word'(req_ready), 1);
    sb.push_back(rsp_t'({e, r}));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    int_src   = src_exec;
    check("exec_rsp_valid", word'(rsp_valid), 0);
    check("exec_req_ready", word'(req_ready), 0);
    @(negedge clk);
    check("latency_rsp_valid", word'(rsp_valid), 1);
  endtask

  // Hold rsp_ready low for 'stall' cycles, then complete the handshake.
  task automatic collect(input int stall);
    rsp_t exp;
    int   waited = 0;
    while (!rsp_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("sb_nonempty", word'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    exp = sb.pop_front();
    for (int k = 0; k < stall; k++) begin
      check("stall_rsp_valid", word'(rsp_valid), 1);
      check("stall_rdata", rsp_rdata, exp.rdata);
      check("stall_req_ready", word'(req_ready), 0);
      @(negedge clk);
    end
    check("rsp_valid", word'(rsp_valid), 1);
    check("rsp_rdata", rsp_rdata, exp.rdata);
    check("rsp_err", word'(rsp_err), word'(exp.err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", word'(rsp_valid), 0);
  endtask

  initial begin
    req_valid = 1'b0; req_op = CSRRW; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; int_src = '0; ack_valid = 1'b0; ack_idx = '0;
    for (int i = 0; i < IntAmount; i++) model[i] = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_req_ready", word'(req_ready), 0);
    check("reset_rsp_valid", word'(rsp_valid), 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", word'(rsp_err), 0);
    check_cfg("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("release_req_ready", word'(req_ready), 1);

    // Basic write, set, and clear racing a hardware rising edge
    issue(CSRRW, 12'hB03, 32'h1D, 1'b0, 32'h0, 8'h00);
    collect(0);
    model[3] = 32'h1D;
    check_cfg("rw");
    issue(CSRRS, 12'hB03, 32'h2, 1'b0, 32'h1D, 8'h00);
    collect(0);
    model[3] = 32'h1F;
    check_cfg("rs");
    issue(CSRRC, 12'hB03, 32'h1, 1'b0, 32'h1F, 8'h08);
    collect(0);
    check_cfg("rc_hw_wins");

    // Ack racing a rising edge, out-of-range ack, then a plain ack
    int_src = 8'h00;
    @(negedge clk);
    int_src = 8'h08; ack_valid = 1'b1; ack_idx = IntIdx'(3);
    @(negedge clk);
    ack_valid = 1'b0;
    check("ack_vs_rise", cfg_to_csr(cfg[3]), 32'h1F);
    ack_valid = 1'b1; ack_idx = IntIdx'(8);
    @(negedge clk);
    ack_valid = 1'b0;
    check("ack_out_of_range", cfg_to_csr(cfg[3]), 32'h1F);
    ack_valid = 1'b1; ack_idx = IntIdx'(3);
    @(negedge clk);
    ack_valid = 1'b0;
    model[3] = 32'h1E;
    check_cfg("ack_clear");

    int_src = 8'h28;
    @(negedge clk);
    model[5] = 32'h1;
    check_cfg("rise5");

    // Immediate forms, unused bits, both ends of the address window
    issue(CSRRSI, 12'hB05, 32'h0, 1'b0, 32'h1, 8'h28);
    collect(0);
    issue(CSRRCI, 12'hB05, 32'h1, 1'b0, 32'h1, 8'h28);
    collect(0);
    model[5] = 32'h0;
    issue(CSRRW, 12'hB07, 32'hFFFF_FFFF, 1'b0, 32'h0, 8'h28);
    collect(0);
    model[7] = 32'h1F;
    issue(CSRRW, 12'hB07, 32'h0, 1'b0, 32'h1F, 8'h28);
    collect(0);
    model[7] = 32'h0;
    issue(CSRRWI, 12'hB00, 32'h0C, 1'b0, 32'h0, 8'h28);
    collect(0);
    model[0] = 32'h0C;
    check_cfg("imm");

    // Error cases leave configuration untouched
    issue(CSRRW, 12'hB08, 32'hFF, 1'b1, 32'h0, 8'h28);
    collect(0);
    issue(ECALL, 12'hB00, 32'h5, 1'b1, 32'h0, 8'h28);
    collect(0);
    issue(csr_op_t'(3'b100), 12'hB01, 32'h2, 1'b1, 32'h0, 8'h28);
    collect(0);
    issue(CSRRW, 12'hAFF, 32'h1, 1'b1, 32'h0, 8'h28);
    collect(0);
    check_cfg("err");

    // Response back-pressure with a competing request held on the bus
    issue(CSRRS, 12'hB01, 32'h2, 1'b0, 32'h0, 8'h28);
    req_op = CSRRS; req_addr = 12'hB02; req_wdata = 32'h4; req_valid = 1'b1;
    collect(5);
    req_valid = 1'b0;
    model[1] = 32'h2;
    check_cfg("stall");
    issue(CSRRS, 12'hB02, 32'h4, 1'b0, 32'h0, 8'h28);
    collect(0);
    model[2] = 32'h4;
    check_cfg("after_stall");

    // Reset asserted while a request is in EXEC
    @(negedge clk);
    req_op = CSRRW; req_addr = 12'hB04; req_wdata = 32'h1F; req_valid = 1'b1;
    check("abort_req_ready", word'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    int_src   = 8'h00;
    reset_n   = 1'b0;
    #1;
    check("abort_rsp_valid", word'(rsp_valid), 0);
    check("abort_req_ready_low", word'(req_ready), 0);
    for (int i = 0; i < IntAmount; i++) model[i] = '0;
    check_cfg("abort");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_abort_rsp_valid", word'(rsp_valid), 0);
      check("post_abort_req_ready", word'(req_ready), 1);
    end
    check_cfg("post_abort");
    check("sb_empty", word'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
